alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_pkg.sv | 68 ++++++
 rtl/alu_flags_reg.sv | 40 ++++
 rtl/alu_ctrl.sv | 109 ++++++++++
 tb/tb_alu_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU controller: function codes, FSM states, flag bit positions.
// ALU_CTRL_CMP_EN turns the RESERVED code into a flag-only compare (SUB) instead of an error.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD      = 3'b000,
    ALU_SUB      = 3'b001,
    ALU_AND      = 3'b010,
    ALU_RESERVED = 3'b011,
    ALU_OR       = 3'b100,
    ALU_XOR      = 3'b101,
    ALU_COPY_B   = 3'b110,
    ALU_NOT_B    = 3'b111
  } alu_func_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } ctrl_state_e;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  // How a latched request affects flags and the response.
  typedef struct packed {
    logic upd_nz;
    logic upd_cv;
    logic err;
    logic zero_data;
  } func_cls_t;

  function automatic func_cls_t classify(alu_func_e f);
    func_cls_t c;
    c = '0;
    case (f)
      ALU_ADD, ALU_SUB: begin
        c.upd_nz = 1'b1;
        c.upd_cv = 1'b1;
      end
      ALU_RESERVED: begin
`ifdef ALU_CTRL_CMP_EN
        c.upd_nz    = 1'b1;
        c.upd_cv    = 1'b1;
        c.zero_data = 1'b1;
`else
        c.err       = 1'b1;
        c.zero_data = 1'b1;
`endif
      end
      default: c.upd_nz = 1'b1;
    endcase
    return c;
  endfunction

  // Operation actually presented to the ALU for a requested function.
  function automatic alu_func_e exec_func(alu_func_e f);
    if (f != ALU_RESERVED) return f;
`ifdef ALU_CTRL_CMP_EN
    return ALU_SUB;
`else
    return ALU_ADD;
`endif
  endfunction

endpackage

// File: rtl/alu_flags_reg.sv
// {N,Z,C,V} status register; N/Z and C/V have separate update enables so
// logical operations can leave carry and overflow untouched.
module alu_flags_reg
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd_nz_i,
  input  logic       upd_cv_i,
  input  logic       n_i,
  input  logic       z_i,
  input  logic       c_i,
  input  logic       v_i,
  output logic [3:0] flags_o
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;

  always_comb begin
    // NOTE: default to the held value first so no path leaves flags_d unassigned (no latch).
    flags_d = flags_q;
    if (upd_nz_i) begin
      flags_d[FLAG_N] = n_i;
      flags_d[FLAG_Z] = z_i;
    end
    if (upd_cv_i) begin
      flags_d[FLAG_C] = c_i;
      flags_d[FLAG_V] = v_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/alu_ctrl.sv
// Request/response sequencer around an external ALU: IDLE latches a request,
// EXEC gives the ALU one stable cycle, RESP holds the result until consumed.
// ALU_CTRL_CMP_EN (see alu_pkg) enables compare handling of the RESERVED code.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  alu_func_e             req_func,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [3:0]            flags,
  output logic [DATA_WIDTH-1:0] alu_op_a,
  output logic [DATA_WIDTH-1:0] alu_op_b,
  output alu_func_e             alu_func,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_signed_overflow,
  input  logic                  alu_carry_flag
);

  ctrl_state_e           state_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] op_a_q;
  logic [DATA_WIDTH-1:0] op_b_q;
  alu_func_e             func_q;
  func_cls_t             cls_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      func_q      <= ALU_ADD;
      cls_q       <= '0;
    end else begin
      // NOTE: every state register uses <= so all of them see pre-edge values this cycle.
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_a_q      <= req_a;
            op_b_q      <= req_b;
            func_q      <= exec_func(req_func);
            cls_q       <= classify(req_func);
            req_ready_q <= 1'b0;
            state_q     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data_q  <= cls_q.zero_data ? '0 : alu_out;
          rsp_err_q   <= cls_q.err;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // Flags are written on the same edge that captures rsp_data.
  logic in_exec;
  assign in_exec = (state_q == ST_EXEC);

  alu_flags_reg u_flags (
    .clk      (clk),
    .rst_n    (rst_n),
    .upd_nz_i (in_exec && cls_q.upd_nz),
    .upd_cv_i (in_exec && cls_q.upd_cv),
    .n_i      (alu_out[DATA_WIDTH-1]),
    .z_i      (alu_out == '0),
    .c_i      (alu_carry_flag),
    .v_i      (alu_signed_overflow),
    .flags_o  (flags)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign alu_op_a  = op_a_q;
  assign alu_op_b  = op_b_q;
  assign alu_func  = func_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl with a behavioural ALU; a scoreboard queue is filled at
// request time and drained by a monitor that checks every response cycle.
module tb_alu_ctrl;
  import alu_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  alu_func_e     req_func;
  logic [DW-1:0] req_a, req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [3:0]    flags;
  logic [DW-1:0] alu_op_a, alu_op_b, alu_out;
  alu_func_e     alu_func;
  logic          alu_signed_overflow, alu_carry_flag;

  always #5 clk = ~clk;

  alu_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_func            (req_func),
    .req_a               (req_a),
    .req_b               (req_b),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_data            (rsp_data),
    .rsp_err             (rsp_err),
    .flags               (flags),
    .alu_op_a            (alu_op_a),
    .alu_op_b            (alu_op_b),
    .alu_func            (alu_func),
    .alu_out             (alu_out),
    .alu_signed_overflow (alu_signed_overflow),
    .alu_carry_flag      (alu_carry_flag)
  );

  // Returns {carry, signed_overflow, result}; carry on SUB means "no borrow".
  function automatic logic [9:0] alu_eval(alu_func_e f, logic [7:0] a, logic [7:0] b);
    int ua, ub, sa, sb, r, s;
    logic c, v;
    logic [7:0] o;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = 1'b0; v = 1'b0; o = 8'h00;
    case (f)
      ALU_ADD: begin
        r = ua + ub; s = sa + sb;
        o = r[7:0]; c = (r > 255); v = (s > 127) || (s < -128);
      end
      ALU_SUB: begin
        r = ua - ub; s = sa - sb;
        o = r[7:0]; c = (ua >= ub); v = (s > 127) || (s < -128);
      end
      ALU_AND:    o = a & b;
      ALU_OR:     o = a | b;
      ALU_XOR:    o = a ^ b;
      ALU_COPY_B: o = b;
      ALU_NOT_B:  o = ~b;
      default: begin o = 8'hA5; c = 1'b1; v = 1'b1; end
    endcase
    return {c, v, o};
  endfunction

  assign {alu_carry_flag, alu_signed_overflow, alu_out} = alu_eval(alu_func, alu_op_a, alu_op_b);

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic [3:0] flags;
    int         offer_cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] mflags;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic       prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: response and new flag state for one request, from the functional rules.
  function automatic exp_t predict(alu_func_e f, logic [7:0] a, logic [7:0] b);
    exp_t x;
    logic [9:0] r;
    logic upd_nz, upd_cv;
    r      = alu_eval((f == ALU_RESERVED) ? ALU_SUB : f, a, b);
    upd_nz = (f != ALU_RESERVED);
    upd_cv = (f == ALU_ADD) || (f == ALU_SUB);
    x.data = r[7:0];
    x.err  = 1'b0;
    x.offer_cyc = 0;
    if (f == ALU_RESERVED) begin
      x.data = 8'h00;
`ifdef ALU_CTRL_CMP_EN
      upd_nz = 1'b1;
      upd_cv = 1'b1;
`else
      x.err  = 1'b1;
`endif
    end
    if (upd_nz) begin
      mflags[FLAG_N] = r[7];
      mflags[FLAG_Z] = (r[7:0] == 8'h00);
    end
    if (upd_cv) begin
      mflags[FLAG_C] = r[9];
      mflags[FLAG_V] = r[8];
    end
    x.flags = mflags;
    return x;
  endfunction

  function automatic alu_func_e expected_alu_func(alu_func_e f);
    if (f != ALU_RESERVED) return f;
`ifdef ALU_CTRL_CMP_EN
    return ALU_SUB;
`else
    return ALU_ADD;
`endif
  endfunction

  task automatic scramble_req();
    req_valid = 1'($urandom_range(0, 1));
    req_func  = alu_func_e'(3'($urandom_range(0, 7)));
    req_a     = 8'($urandom);
    req_b     = 8'($urandom);
  endtask

  // One transaction; the response fields seen at handshake are returned for directed checks.
  task automatic send(input alu_func_e f, input logic [7:0] a, input logic [7:0] b,
                      input int hold, output logic [7:0] d, output logic e, output logic [3:0] fl);
    exp_t x;
    int   waitc;
    d = 8'h00; e = 1'b0; fl = 4'h0;
    @(negedge clk);
    check("req_ready_before_offer", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_func = f; req_a = a; req_b = b;
    x = predict(f, a, b);
    x.offer_cyc = cyc;
    sb_q.push_back(x);
    @(negedge clk);
    check("alu_drive_exec", {21'd0, alu_func, alu_op_a, alu_op_b}, {21'd0, expected_alu_func(f), a, b});
    scramble_req();
    waitc = 0;
    while (!rsp_valid && waitc < 8) begin
      @(negedge clk);
      scramble_req();
      waitc++;
    end
    if (!rsp_valid) begin
      check("rsp_valid_timeout", {31'd0, rsp_valid}, 32'd1);
      sb_q.delete();
      req_valid = 1'b0;
      return;
    end
    repeat (hold) begin
      @(negedge clk);
      scramble_req();
    end
    d = rsp_data; e = rsp_err; fl = flags;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("idle_after_rsp", {31'd0, req_ready}, 32'd1);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst_n && rsp_valid && rsp_ready && sb_q.size() > 0) void'(sb_q.pop_front());
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
      end else begin
        check("rsp_data", {24'd0, rsp_data}, {24'd0, sb_q[0].data});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, sb_q[0].err});
        check("flags", {28'd0, flags}, {28'd0, sb_q[0].flags});
        check("req_ready_busy", {31'd0, req_ready}, 32'd0);
        if (!prev_valid) check("rsp_latency", 32'(cyc - sb_q[0].offer_cyc), 32'd2);
      end
    end
    prev_valid = rsp_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       e;
    logic [3:0] fl;
    alu_func_e  rf;

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_func = ALU_ADD; req_a = '0; req_b = '0;
    mflags = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    check("rst_alu_ops", {16'd0, alu_op_a, alu_op_b}, 32'd0);
    check("rst_alu_func", {29'd0, alu_func}, {29'd0, ALU_ADD});
    rst_n = 1'b1;

    // Signed overflow into the sign bit.
    send(ALU_ADD, 8'h7F, 8'h01, 0, d, e, fl);
    check("add_ovf_data", {24'd0, d}, 32'h80);
    check("add_ovf_flags", {28'd0, fl}, 32'b1001);

    // Logical op keeps C=0, V=1 from the ADD.
    send(ALU_AND, 8'hF0, 8'h0F, 0, d, e, fl);
    check("and_data", {24'd0, d}, 32'h00);
    check("and_flags", {28'd0, fl}, 32'b0101);

    // Equal operands, with backpressure on the response.
    send(ALU_SUB, 8'h05, 8'h05, 5, d, e, fl);
    check("sub_eq_data", {24'd0, d}, 32'h00);
    check("sub_eq_flags", {28'd0, fl}, 32'b0110);

    send(ALU_RESERVED, 8'h03, 8'h05, 1, d, e, fl);
    check("rsv_data", {24'd0, d}, 32'h00);
`ifdef ALU_CTRL_CMP_EN
    check("rsv_err", {31'd0, e}, 32'd0);
    check("rsv_flags", {28'd0, fl}, 32'b1000);
`else
    check("rsv_err", {31'd0, e}, 32'd1);
    check("rsv_flags", {28'd0, fl}, 32'b0110);
`endif

    // Reset while EXEC is in progress: the request must vanish.
    @(negedge clk);
    req_valid = 1'b1; req_func = ALU_ADD; req_a = 8'hFF; req_b = 8'hFF;
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("exec_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("exec_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("exec_rst_flags", {28'd0, flags}, 32'd0);
    rst_n = 1'b1;
    mflags = 4'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("exec_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    for (int i = 0; i < 150; i++) begin
      rf = alu_func_e'(3'($urandom_range(0, 7)));
      send(rf, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), d, e, fl);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
